// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC bus sequencer.
//   state_t    - sequencer states
//   ADDR_*     - RTC register addresses
//   N_ACC      - accesses per burst (9 with RTC_TIMER_EN defined, else 6)
//   rtc_addr() - access index to RTC register address
// Build option: define RTC_TIMER_EN to include the three timer registers.
package rtc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A_SU,
    A_STB,
    A_HD,
    D_SU,
    D_STB,
    D_HD,
    NEXT,
    DONE
  } state_t;

  localparam logic [7:0] ADDR_SEG = 8'h21;
  localparam logic [7:0] ADDR_MIN = 8'h22;
  localparam logic [7:0] ADDR_HOR = 8'h23;
  localparam logic [7:0] ADDR_DIA = 8'h24;
  localparam logic [7:0] ADDR_MES = 8'h25;
  localparam logic [7:0] ADDR_ANO = 8'h26;
  localparam logic [7:0] ADDR_TS  = 8'h41;
  localparam logic [7:0] ADDR_TM  = 8'h42;
  localparam logic [7:0] ADDR_TH  = 8'h43;

`ifdef RTC_TIMER_EN
  localparam int N_ACC = 9;
`else
  localparam int N_ACC = 6;
`endif

  // Access order: date/time first (seconds upward), then the timer.
  function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = ADDR_SEG;
      4'd1:    a = ADDR_MIN;
      4'd2:    a = ADDR_HOR;
      4'd3:    a = ADDR_DIA;
      4'd4:    a = ADDR_MES;
      4'd5:    a = ADDR_ANO;
      4'd6:    a = ADDR_TS;
      4'd7:    a = ADDR_TM;
      4'd8:    a = ADDR_TH;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_bus_phase.sv
// rtc_bus_phase: cycle counter for one setup/strobe/hold phase.
//   clk, reset  - clock, synchronous active-high reset
//   restart     - hold the counter at zero (sequencer not in a timed state)
//   len         - length of the current phase in cycles (>=1)
//   phase_done  - high on the last cycle of the current phase
// The counter returns to zero on phase_done, so back-to-back phases of
// different lengths chain without an idle cycle.
module rtc_bus_phase (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic [7:0] len,
  output logic       phase_done
);

  logic [7:0] count_reg;

  assign phase_done = !restart && (count_reg == len - 8'd1);

  always_ff @(posedge clk) begin
    if (reset || restart || phase_done) begin
      count_reg <= 8'd0;
    end else begin
      count_reg <= count_reg + 8'd1;
    end
  end

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: writes latched date/time(/timer) bytes into an external RTC
// over a multiplexed address/data bus, or reads them back.
//   clk, reset              - clock, synchronous active-high reset
//   escribir / leer         - start write / read burst (sampled in IDLE, write wins)
//   ano..st                 - bytes to write
//   anole..stle             - bytes read back (updated together at burst end)
//   Listo_es                - burst complete, held until next start
//   ad_out, ad_in, ad_oe    - multiplexed bus (driven value, sampled value, enable)
//   cs_n, rd_n, wr_n, a_d   - RTC chip select, strobes, address(0)/data(1) select
// Build option: RTC_TIMER_EN adds the timer registers (ht/mt/st) to each burst.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int T_SU  = 1,
  parameter int T_STB = 4,
  parameter int T_HD  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       escribir,
  input  logic       leer,
  input  logic [7:0] ano,
  input  logic [7:0] mes,
  input  logic [7:0] dia,
  input  logic [7:0] horas,
  input  logic [7:0] minutos,
  input  logic [7:0] segundos,
  input  logic [7:0] ht,
  input  logic [7:0] mt,
  input  logic [7:0] st,
  output logic [7:0] anole,
  output logic [7:0] mesle,
  output logic [7:0] diale,
  output logic [7:0] horasle,
  output logic [7:0] minutosle,
  output logic [7:0] segundosle,
  output logic [7:0] htle,
  output logic [7:0] mtle,
  output logic [7:0] stle,
  output logic       Listo_es,
  output logic [7:0] ad_out,
  input  logic [7:0] ad_in,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d
);

  state_t     state_reg;
  logic [3:0] idx_reg;
  logic       op_read_reg;
  logic       phase_done;
  logic       phase_restart;
  logic [7:0] phase_len;
  logic [7:0] src_byte;
  logic [7:0] shadow [N_ACC];

  always_comb begin
    phase_len     = 8'd1;
    phase_restart = 1'b0;
    case (state_reg)
      A_SU, D_SU:   phase_len = 8'(T_SU);
      A_STB, D_STB: phase_len = 8'(T_STB);
      A_HD, D_HD:   phase_len = 8'(T_HD);
      default:      phase_restart = 1'b1;
    endcase
  end

  rtc_bus_phase u_phase (
    .clk        (clk),
    .reset      (reset),
    .restart    (phase_restart),
    .len        (phase_len),
    .phase_done (phase_done)
  );

  always_comb begin
    src_byte = 8'h00;
    case (idx_reg)
      4'd0: src_byte = segundos;
      4'd1: src_byte = minutos;
      4'd2: src_byte = horas;
      4'd3: src_byte = dia;
      4'd4: src_byte = mes;
      4'd5: src_byte = ano;
`ifdef RTC_TIMER_EN
      4'd6: src_byte = st;
      4'd7: src_byte = mt;
      4'd8: src_byte = ht;
`endif
      default: src_byte = 8'h00;
    endcase
  end

`ifndef RTC_TIMER_EN
  logic unused_timer;
  assign unused_timer = ^{ht, mt, st};
`endif

  // Bus outputs are set on the transition into each state so they come
  // straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= 4'd0;
      op_read_reg <= 1'b0;
      Listo_es    <= 1'b0;
      ad_out      <= 8'h00;
      ad_oe       <= 1'b0;
      cs_n        <= 1'b1;
      rd_n        <= 1'b1;
      wr_n        <= 1'b1;
      a_d         <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (escribir || leer) begin
            op_read_reg <= !escribir;
            Listo_es    <= 1'b0;
            idx_reg     <= 4'd0;
            state_reg   <= A_SU;
            a_d         <= 1'b0;
            ad_oe       <= 1'b1;
            ad_out      <= rtc_addr(4'd0);
            cs_n        <= 1'b0;
          end
        end
        A_SU: if (phase_done) begin
          state_reg <= A_STB;
          wr_n      <= 1'b0;
        end
        A_STB: if (phase_done) begin
          state_reg <= A_HD;
          wr_n      <= 1'b1;
        end
        A_HD: if (phase_done) begin
          // Source byte is sampled here, at the start of the data phase.
          state_reg <= D_SU;
          a_d       <= 1'b1;
          ad_oe     <= !op_read_reg;
          if (!op_read_reg) ad_out <= src_byte;
        end
        D_SU: if (phase_done) begin
          state_reg <= D_STB;
          if (op_read_reg) rd_n <= 1'b0;
          else             wr_n <= 1'b0;
        end
        D_STB: if (phase_done) begin
          state_reg <= D_HD;
          rd_n      <= 1'b1;
          wr_n      <= 1'b1;
        end
        D_HD: if (phase_done) begin
          state_reg <= NEXT;
          cs_n      <= 1'b1;
          ad_oe     <= 1'b0;
        end
        NEXT: begin
          if (idx_reg == 4'(N_ACC - 1)) begin
            state_reg <= DONE;
            idx_reg   <= 4'd0;
          end else begin
            idx_reg   <= idx_reg + 4'd1;
            state_reg <= A_SU;
            cs_n      <= 1'b0;
            a_d       <= 1'b0;
            ad_oe     <= 1'b1;
            ad_out    <= rtc_addr(idx_reg + 4'd1);
          end
        end
        DONE: begin
          Listo_es  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // One shadow byte per access; captured on the final strobe cycle so the
  // RTC has had the full strobe width to drive the bus.
  genvar gi;
  generate
    for (gi = 0; gi < N_ACC; gi++) begin : g_shadow
      logic [7:0] sh_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          sh_reg <= 8'h00;
        end else if (state_reg == D_STB && phase_done && op_read_reg &&
                     idx_reg == 4'(gi)) begin
          sh_reg <= ad_in;
        end
      end
      assign shadow[gi] = sh_reg;
    end
  endgenerate

  // All read-back bytes change on one edge so the PicoBlaze never sees a
  // mix of old and new values.
  always_ff @(posedge clk) begin
    if (reset) begin
      segundosle <= 8'h00;
      minutosle  <= 8'h00;
      horasle    <= 8'h00;
      diale      <= 8'h00;
      mesle      <= 8'h00;
      anole      <= 8'h00;
    end else if (state_reg == DONE && op_read_reg) begin
      segundosle <= shadow[0];
      minutosle  <= shadow[1];
      horasle    <= shadow[2];
      diale      <= shadow[3];
      mesle      <= shadow[4];
      anole      <= shadow[5];
    end
  end

`ifdef RTC_TIMER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stle <= 8'h00;
      mtle <= 8'h00;
      htle <= 8'h00;
    end else if (state_reg == DONE && op_read_reg) begin
      stle <= shadow[6];
      mtle <= shadow[7];
      htle <= shadow[8];
    end
  end
`else
  assign stle = 8'h00;
  assign mtle = 8'h00;
  assign htle = 8'h00;
`endif

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
module tb_rtc_bus_ctrl;

`ifdef RTC_TIMER_EN
  localparam int N = 9;
`else
  localparam int N = 6;
`endif
  localparam int LAT = 1 + N * (2 * (1 + 4 + 1) + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic escribir = 1'b0;
  logic leer = 1'b0;
  logic [7:0] ano = 8'h00, mes = 8'h00, dia = 8'h00, horas = 8'h00;
  logic [7:0] minutos = 8'h00, segundos = 8'h00, ht = 8'h00, mt = 8'h00, st = 8'h00;
  logic [7:0] anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle;
  logic Listo_es;
  logic [7:0] ad_out, ad_in;
  logic ad_oe, cs_n, rd_n, wr_n, a_d;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rtc_bus_ctrl dut (
    .clk(clk), .reset(reset), .escribir(escribir), .leer(leer),
    .ano(ano), .mes(mes), .dia(dia), .horas(horas), .minutos(minutos),
    .segundos(segundos), .ht(ht), .mt(mt), .st(st),
    .anole(anole), .mesle(mesle), .diale(diale), .horasle(horasle),
    .minutosle(minutosle), .segundosle(segundosle), .htle(htle),
    .mtle(mtle), .stle(stle), .Listo_es(Listo_es),
    .ad_out(ad_out), .ad_in(ad_in), .ad_oe(ad_oe),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d)
  );

  // RTC register contents seen by read bursts.
  function automatic logic [7:0] rtc_val(input logic [7:0] a);
    case (a)
      8'h21: return 8'h59;
      8'h22: return 8'h30;
      8'h23: return 8'h12;
      8'h24: return 8'h31;
      8'h25: return 8'h12;
      8'h26: return 8'h99;
      8'h41: return 8'h10;
      8'h42: return 8'h20;
      8'h43: return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_addr(input int i);
    case (i)
      0: return 8'h21; 1: return 8'h22; 2: return 8'h23;
      3: return 8'h24; 4: return 8'h25; 5: return 8'h26;
      6: return 8'h41; 7: return 8'h42; 8: return 8'h43;
      default: return 8'h00;
    endcase
  endfunction

  // Bus monitor / RTC model
  logic [7:0] cur_addr = 8'h00;
  logic [7:0] log_addr[$];
  logic [7:0] log_data[$];
  int wr_runs[$];
  int wr_run = 0;
  int rd_low = 0;
  int oe_rd_data = 0;
  bit read_mode = 1'b0;
  logic wr_prev = 1'b1;

  assign ad_in = (!rd_n && a_d) ? rtc_val(cur_addr) : 8'h00;

  always @(negedge clk) begin
    if (!cs_n && !a_d && !wr_n) cur_addr = ad_out;
    if (!cs_n && a_d && !wr_n && wr_prev) begin
      log_addr.push_back(cur_addr);
      log_data.push_back(ad_out);
    end
    if (!wr_n) wr_run++;
    else if (wr_run != 0) begin
      wr_runs.push_back(wr_run);
      wr_run = 0;
    end
    if (!rd_n) rd_low++;
    if (read_mode && !cs_n && a_d && ad_oe) oe_rd_data++;
    wr_prev = wr_n;
  end

  task automatic clear_mon();
    log_addr.delete();
    log_data.delete();
    wr_runs.delete();
    wr_run = 0;
    rd_low = 0;
    oe_rd_data = 0;
  endtask

  // Drive a one-cycle request; returns 1 ns after the start edge.
  task automatic pulse(input logic w, input logic r);
    @(negedge clk);
    escribir = w;
    leer = r;
    @(posedge clk);
    #1;
    escribir = 1'b0;
    leer = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!Listo_es && k < 400);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({cs_n, rd_n, wr_n, a_d} !== 4'b1111) begin
      bad++; $display("FAIL reset_strobes: got %b want 1111", {cs_n, rd_n, wr_n, a_d});
    end
    total++;
    if ({ad_oe, Listo_es, ad_out} !== 10'h000) begin
      bad++; $display("FAIL reset_bus: got oe=%b listo=%b ad=%h want 0 0 00", ad_oe, Listo_es, ad_out);
    end
    total++;
    if ({anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle} !== 72'h0) begin
      bad++; $display("FAIL reset_le: got %h want 0", {anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle});
    end
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_write();
    int k;
    logic [7:0] exp_d [9];
    segundos = 8'h45; minutos = 8'h37; horas = 8'h08; dia = 8'h15;
    mes = 8'h11; ano = 8'h16; st = 8'h05; mt = 8'h03; ht = 8'h02;
    exp_d[0] = 8'h45; exp_d[1] = 8'h37; exp_d[2] = 8'h08; exp_d[3] = 8'h15;
    exp_d[4] = 8'h11; exp_d[5] = 8'h16; exp_d[6] = 8'h05; exp_d[7] = 8'h03; exp_d[8] = 8'h02;
    clear_mon();
    pulse(1'b1, 1'b0);
    total++;
    if (Listo_es !== 1'b0) begin
      bad++; $display("FAIL write_listo_start: got %b want 0", Listo_es);
    end
    wait_done(k);
    total++;
    if (k != LAT) begin
      bad++; $display("FAIL write_latency: got %0d want %0d", k, LAT);
    end
    total++;
    if (log_addr.size() != N) begin
      bad++; $display("FAIL write_count: got %0d want %0d", log_addr.size(), N);
    end
    for (int i = 0; i < N && i < log_addr.size(); i++) begin
      total++;
      if (log_addr[i] !== exp_addr(i) || log_data[i] !== exp_d[i]) begin
        bad++; $display("FAIL write_entry%0d: got %h/%h want %h/%h", i, log_addr[i], log_data[i], exp_addr(i), exp_d[i]);
      end
    end
    total++;
    if (wr_runs.size() != 2 * N) begin
      bad++; $display("FAIL write_strobes: got %0d want %0d", wr_runs.size(), 2 * N);
    end
    for (int i = 0; i < wr_runs.size(); i++) begin
      total++;
      if (wr_runs[i] != 4) begin
        bad++; $display("FAIL write_strobe_width%0d: got %0d want 4", i, wr_runs[i]);
      end
    end
    total++;
    if (rd_low != 0) begin
      bad++; $display("FAIL write_rd_idle: got %0d rd cycles want 0", rd_low);
    end
    $display("test_write: latency=%0d accesses=%0d", k, log_addr.size());
  endtask

  task automatic test_read();
    int k;
    int early;
    logic [71:0] exp_le;
`ifdef RTC_TIMER_EN
    exp_le = {8'h99, 8'h12, 8'h31, 8'h12, 8'h30, 8'h59, 8'h01, 8'h20, 8'h10};
`else
    exp_le = {8'h99, 8'h12, 8'h31, 8'h12, 8'h30, 8'h59, 8'h00, 8'h00, 8'h00};
`endif
    total++;
    if (Listo_es !== 1'b1) begin
      bad++; $display("FAIL read_listo_before: got %b want 1", Listo_es);
    end
    clear_mon();
    read_mode = 1'b1;
    pulse(1'b0, 1'b1);
    total++;
    if (Listo_es !== 1'b0) begin
      bad++; $display("FAIL read_listo_drop: got %b want 0", Listo_es);
    end
    k = 0;
    early = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (!Listo_es && {anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle} !== 72'h0)
        early++;
    end while (!Listo_es && k < 400);
    read_mode = 1'b0;
    total++;
    if (k != LAT) begin
      bad++; $display("FAIL read_latency: got %0d want %0d", k, LAT);
    end
    total++;
    if (early != 0) begin
      bad++; $display("FAIL read_early_update: got %0d cycles with partial values want 0", early);
    end
    total++;
    if ({anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle} !== exp_le) begin
      bad++; $display("FAIL read_values: got %h want %h", {anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle}, exp_le);
    end
    total++;
    if (oe_rd_data != 0) begin
      bad++; $display("FAIL read_oe: got %0d driven data cycles want 0", oe_rd_data);
    end
    total++;
    if (rd_low != 4 * N) begin
      bad++; $display("FAIL read_rd_cycles: got %0d want %0d", rd_low, 4 * N);
    end
    total++;
    if (log_addr.size() != 0) begin
      bad++; $display("FAIL read_no_write: got %0d data writes want 0", log_addr.size());
    end
    $display("test_read: latency=%0d segundosle=%h anole=%h", k, segundosle, anole);
  endtask

  task automatic test_both();
    int k;
    int cs_low;
    clear_mon();
    pulse(1'b1, 1'b1);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (k == 30) leer = 1'b1;
      if (k == 32) leer = 1'b0;
    end while (!Listo_es && k < 400);
    total++;
    if (k != LAT) begin
      bad++; $display("FAIL both_latency: got %0d want %0d", k, LAT);
    end
    total++;
    if (rd_low != 0 || wr_runs.size() != 2 * N) begin
      bad++; $display("FAIL both_write_wins: got rd=%0d wr_strobes=%0d want 0 %0d", rd_low, wr_runs.size(), 2 * N);
    end
    cs_low = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (!cs_n || !Listo_es) cs_low++;
    end
    total++;
    if (cs_low != 0) begin
      bad++; $display("FAIL both_single_burst: got %0d active cycles after done want 0", cs_low);
    end
    $display("test_both: latency=%0d", k);
  endtask

  task automatic test_reset_mid();
    int act;
    clear_mon();
    pulse(1'b1, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({cs_n, wr_n, rd_n, a_d, ad_oe, Listo_es} !== 6'b111100) begin
      bad++; $display("FAIL midreset_bus: got %b want 111100", {cs_n, wr_n, rd_n, a_d, ad_oe, Listo_es});
    end
    total++;
    if ({anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle} !== 72'h0) begin
      bad++; $display("FAIL midreset_le: got %h want 0", {anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (!cs_n || Listo_es) act++;
    end
    total++;
    if (act != 0) begin
      bad++; $display("FAIL midreset_idle: got %0d active cycles want 0", act);
    end
    $display("test_reset_mid: done");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_both();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
